// File: rtl/rst_sequencer.sv
// rtl/rst_sequencer.sv - staged reset-release controller for downstream domains
// Holds every domain in reset, then releases them in order as each acknowledges.
module rst_sequencer #(
  parameter int NUM_DOMAINS = 4,
  parameter int HOLD_CYCLES = 16,
  parameter int ACK_TIMEOUT = 255
) (
  input  logic                   CLK,
  input  logic                   RST,
  input  logic                   SW_RST_REQ,
  input  logic [NUM_DOMAINS-1:0] DOMAIN_ACK,
  output logic [NUM_DOMAINS-1:0] DOMAIN_RST_N,
  output logic                   SEQ_DONE,
  output logic                   SEQ_ERR,
  output logic [2:0]             ERR_DOMAIN
);

  typedef enum logic [1:0] {HOLD, WAIT_ACK, DONE, ERROR} state_t;

  localparam logic [2:0]             LAST_IDX  = 3'(NUM_DOMAINS - 1);
  localparam logic [7:0]             HOLD_LAST = 8'(HOLD_CYCLES - 1);
  localparam logic [7:0]             TO_LAST   = 8'(ACK_TIMEOUT - 1);
  localparam logic [NUM_DOMAINS-1:0] ONE       = {{(NUM_DOMAINS-1){1'b0}}, 1'b1};

  state_t                   state, state_nxt;
  logic [7:0]               cnt, cnt_nxt;
  logic [2:0]               idx, idx_nxt;
  logic [2:0]               idx_inc;
  logic [NUM_DOMAINS-1:0]   rst_n_nxt;
  logic                     done_nxt, err_nxt;
  logic [2:0]               err_dom_nxt;
  logic [7:0]               ack_ext;
  logic                     ack_cur;

  // Widen so the 3-bit index selects cleanly for any legal domain count.
  assign ack_ext = 8'(DOMAIN_ACK);
  assign ack_cur = ack_ext[idx];
  assign idx_inc = idx + 3'd1;

  always_comb begin
    state_nxt   = state;
    cnt_nxt     = cnt;
    idx_nxt     = idx;
    rst_n_nxt   = DOMAIN_RST_N;
    done_nxt    = SEQ_DONE;
    err_nxt     = SEQ_ERR;
    err_dom_nxt = ERR_DOMAIN;
    case (state)
      HOLD: begin
        rst_n_nxt = '0;
        if (cnt == HOLD_LAST) begin
          state_nxt = WAIT_ACK;
          cnt_nxt   = 8'd0;
          idx_nxt   = 3'd0;
          rst_n_nxt = ONE;
        end else begin
          cnt_nxt = cnt + 8'd1;
        end
      end
      WAIT_ACK: begin
        if (ack_cur) begin
          if (idx < LAST_IDX) begin
            idx_nxt   = idx_inc;
            cnt_nxt   = 8'd0;
            rst_n_nxt = DOMAIN_RST_N | (ONE << idx_inc);
          end else begin
            state_nxt = DONE;
            done_nxt  = 1'b1;
          end
        end else if (cnt == TO_LAST) begin
          state_nxt   = ERROR;
          err_nxt     = 1'b1;
          err_dom_nxt = idx;
          rst_n_nxt   = '0;
        end else begin
          cnt_nxt = cnt + 8'd1;
        end
      end
      DONE:    ;
      ERROR:   rst_n_nxt = '0;
      default: state_nxt = HOLD;
    endcase
  end

  // A software restart is indistinguishable from a hard reset.
  always_ff @(posedge CLK) begin
    if (RST || SW_RST_REQ) begin
      state        <= HOLD;
      cnt          <= 8'd0;
      idx          <= 3'd0;
      DOMAIN_RST_N <= '0;
      SEQ_DONE     <= 1'b0;
      SEQ_ERR      <= 1'b0;
      ERR_DOMAIN   <= 3'd0;
    end else begin
      state        <= state_nxt;
      cnt          <= cnt_nxt;
      idx          <= idx_nxt;
      DOMAIN_RST_N <= rst_n_nxt;
      SEQ_DONE     <= done_nxt;
      SEQ_ERR      <= err_nxt;
      ERR_DOMAIN   <= err_dom_nxt;
    end
  end

endmodule

// File: tb/tb_rst_sequencer.sv
// tb/tb_rst_sequencer.sv - scoreboard bench for rst_sequencer
// Ack stimulus comes from per-domain delays applied to the reference release state.
module tb_rst_sequencer;

  localparam int N    = 4;
  localparam int HOLD = 16;
  localparam int TO   = 8;

  logic         CLK;
  logic         RST;
  logic         SW_RST_REQ;
  logic [N-1:0] DOMAIN_ACK;
  logic [N-1:0] DOMAIN_RST_N;
  logic         SEQ_DONE;
  logic         SEQ_ERR;
  logic [2:0]   ERR_DOMAIN;

  rst_sequencer #(.NUM_DOMAINS(N), .HOLD_CYCLES(HOLD), .ACK_TIMEOUT(TO)) dut (
    .CLK(CLK), .RST(RST), .SW_RST_REQ(SW_RST_REQ), .DOMAIN_ACK(DOMAIN_ACK),
    .DOMAIN_RST_N(DOMAIN_RST_N), .SEQ_DONE(SEQ_DONE), .SEQ_ERR(SEQ_ERR),
    .ERR_DOMAIN(ERR_DOMAIN)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  int n_assert = 0;
  int n_fail   = 0;

  // Reference state: phase 0 hold, 1 waiting, 2 done, 3 error.
  int m_phase, m_cnt, m_idx, m_rel, m_errdom;
  logic m_done, m_err;
  int age [N];
  int dly [N];  // -1 never acks, -2 tied high, else edges after release
  logic [8:0] sb [$];

  int ecnt;
  int t_rel [N];
  int t_done, t_err;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_step(input logic r, input logic s, input logic [N-1:0] a);
    int prev;
    prev = m_rel;
    if (r || s) begin
      m_phase = 0; m_cnt = 0; m_idx = 0; m_rel = 0;
      m_done = 1'b0; m_err = 1'b0; m_errdom = 0;
    end else begin
      case (m_phase)
        0: begin
          m_cnt++;
          if (m_cnt == HOLD) begin m_phase = 1; m_cnt = 0; m_rel = 1; end
        end
        1: begin
          if (a[m_idx]) begin
            if (m_idx < N - 1) begin m_idx++; m_rel = m_idx + 1; m_cnt = 0; end
            else begin m_phase = 2; m_done = 1'b1; end
          end else begin
            m_cnt++;
            if (m_cnt == TO) begin m_phase = 3; m_err = 1'b1; m_errdom = m_idx; m_rel = 0; end
          end
        end
        default: ;
      endcase
    end
    for (int i = 0; i < N; i++)
      age[i] = (i < m_rel && i < prev) ? age[i] + 1 : 0;
  endtask

  function automatic logic [N-1:0] make_ack();
    logic [N-1:0] a;
    for (int i = 0; i < N; i++)
      a[i] = (dly[i] == -2) || (dly[i] >= 0 && i < m_rel && age[i] >= dly[i]);
    return a;
  endfunction

  task automatic cycle(input logic r, input logic s);
    logic [8:0] exp;
    logic [N-1:0] mask;
    RST = r;
    SW_RST_REQ = s;
    DOMAIN_ACK = make_ack();
    model_step(r, s, DOMAIN_ACK);
    mask = N'((1 << m_rel) - 1);
    sb.push_back({mask, m_done, m_err, 3'(m_errdom)});
    @(posedge CLK);
    #1;
    if (r || s) begin
      ecnt = 0;
      for (int i = 0; i < N; i++) t_rel[i] = -1;
      t_done = -1;
      t_err = -1;
    end else begin
      ecnt++;
    end
    for (int i = 0; i < N; i++)
      if (DOMAIN_RST_N[i] && t_rel[i] < 0) t_rel[i] = ecnt;
    if (SEQ_DONE && t_done < 0) t_done = ecnt;
    if (SEQ_ERR && t_err < 0) t_err = ecnt;
    exp = sb.pop_front();
    check("outputs", {DOMAIN_RST_N, SEQ_DONE, SEQ_ERR, ERR_DOMAIN}, exp);
  endtask

  task automatic run(input int n);
    repeat (n) cycle(1'b0, 1'b0);
  endtask

  task automatic set_dly(input int d0, input int d1, input int d2, input int d3);
    dly[0] = d0; dly[1] = d1; dly[2] = d2; dly[3] = d3;
  endtask

  initial begin
    RST = 1'b1; SW_RST_REQ = 1'b0; DOMAIN_ACK = '0;
    for (int i = 0; i < N; i++) begin age[i] = 0; dly[i] = -1; end
    m_phase = 0; m_cnt = 0; m_idx = 0; m_rel = 0; m_errdom = 0;
    m_done = 1'b0; m_err = 1'b0;

    cycle(1'b1, 1'b0);
    cycle(1'b1, 1'b0);
    check("reset_state", {DOMAIN_RST_N, SEQ_DONE, SEQ_ERR, ERR_DOMAIN}, 9'h0);

    // Acks three cycles after each release.
    set_dly(3, 3, 3, 3);
    cycle(1'b1, 1'b0);
    run(40);
    check("s1_rel0", t_rel[0], 16);
    check("s1_rel1", t_rel[1], 20);
    check("s1_rel2", t_rel[2], 24);
    check("s1_rel3", t_rel[3], 28);
    check("s1_done", t_done, 32);
    check("s1_no_err", t_err, -1);

    // All acks tied high; then acks drop while done.
    set_dly(-2, -2, -2, -2);
    cycle(1'b1, 1'b0);
    run(25);
    check("s2_rel0", t_rel[0], 16);
    check("s2_rel3", t_rel[3], 19);
    check("s2_done", t_done, 20);
    set_dly(-1, -1, -1, -1);
    run(5);
    check("s2_done_held", SEQ_DONE, 1);
    cycle(1'b1, 1'b0);
    check("s2_rst_in_done", {DOMAIN_RST_N, SEQ_DONE}, 5'h0);
    set_dly(-2, -2, -2, -2);
    run(22);
    check("s2_rerun_rel0", t_rel[0], 16);
    check("s2_rerun_done", t_done, 20);

    // Domain 2 never acks, then a restart resequences cleanly.
    set_dly(0, 0, -1, 0);
    cycle(1'b1, 1'b0);
    run(35);
    check("s3_err_edge", t_err, 26);
    check("s3_err_dom", ERR_DOMAIN, 2);
    check("s3_rel3_never", t_rel[3], -1);
    set_dly(0, 0, 0, 0);
    cycle(1'b0, 1'b1);
    run(25);
    check("s3_restart_rel0", t_rel[0], 16);
    check("s3_restart_done", t_done, 20);
    check("s3_restart_no_err", t_err, -1);

    // Domain 1 ack on the last allowed wait edge, then one edge late.
    set_dly(0, 7, 0, 0);
    cycle(1'b1, 1'b0);
    run(35);
    check("s4_rel2", t_rel[2], 25);
    check("s4_no_err", t_err, -1);
    check("s4_done", t_done, 27);
    set_dly(0, 8, 0, 0);
    cycle(1'b1, 1'b0);
    run(35);
    check("s4_late_err", t_err, 25);
    check("s4_late_dom", ERR_DOMAIN, 1);
    check("s4_late_rel2", t_rel[2], -1);

    // Restart while waiting on domain 1.
    set_dly(0, -1, 0, 0);
    cycle(1'b1, 1'b0);
    run(20);
    cycle(1'b0, 1'b1);
    check("s5_restart_clear", DOMAIN_RST_N, 0);
    run(20);
    check("s5_hold_repeat", t_rel[0], 16);

    // Only an out-of-order ack from domain 3.
    set_dly(-1, -1, -1, -2);
    cycle(1'b1, 1'b0);
    run(30);
    check("s6_rel1_never", t_rel[1], -1);
    check("s6_err_edge", t_err, 24);
    check("s6_err_dom", ERR_DOMAIN, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
